// File: rtl/render_sequencer.sv
// rtl/render_sequencer.sv - render controller: clear shaders, stream voxel/palette reads, write frame, interrupt
module render_sequencer #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TOTAL_ROWS      = 4,
  parameter int TOTAL_COLS      = 4,
  parameter int COUNT_W         = 24,
  parameter int PIX_W           = $clog2(TOTAL_ROWS * TOTAL_COLS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               do_render,
  input  logic               abort,
  input  logic               clear_interrupt,
  input  logic [ADDR_W-1:0]  voxel_buffer,
  input  logic [ADDR_W-1:0]  palette_buffer,
  input  logic [ADDR_W-1:0]  pixel_buffer,
  input  logic [COUNT_W-1:0] voxel_count,
  input  logic [COUNT_W-1:0] palette_length,
  output logic [ADDR_W-1:0]  m1_address,
  output logic               m1_read,
  output logic               m1_write,
  output logic [DATA_W-1:0]  m1_writedata,
  input  logic               m1_waitrequest,
  input  logic [DATA_W-1:0]  m1_readdata,
  input  logic               m1_readdatavalid,
  output logic               clear_pixels,
  output logic               elem_valid,
  output logic               elem_kind,
  output logic [COUNT_W-1:0] elem_index,
  output logic [DATA_W-1:0]  elem_data,
  input  logic               elem_ready,
  output logic [PIX_W-1:0]   pix_index,
  input  logic [DATA_W-1:0]  pix_data,
  output logic               busy,
  output logic               aborted,
  output logic               irq
);
  localparam int NPIX  = TOTAL_ROWS * TOTAL_COLS;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(DATA_W / 8);
  localparam logic [PIX_W-1:0]  LAST_PIX = PIX_W'(NPIX - 1);
  localparam logic [CNT_W:0]    CREDIT   = (CNT_W + 1)'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_VOXELS, S_PALETTE, S_PIX_SETUP, S_WRITE, S_ABORT_DRAIN, S_INTERRUPT
  } state_t;

  state_t             state;
  logic [COUNT_W-1:0] vox_count_q, pal_count_q, phase_count, issued, accepted;
  logic [ADDR_W-1:0]  vox_base_q, pal_base_q, pix_base_q;
  logic [CNT_W-1:0]   inflight, occupancy;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [DATA_W-1:0]  fifo_mem [MAX_OUTSTANDING];
  logic               abort_pending;
  logic               fetching, issue, rsp, push, pop, phase_done;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit covers both reads in flight and buffered responses, so the FIFO cannot overflow.
  assign fetching     = (state == S_VOXELS) || (state == S_PALETTE);
  assign m1_read      = fetching && (issued < phase_count) &&
                        (({1'b0, inflight} + {1'b0, occupancy}) < CREDIT);
  assign issue        = m1_read && !m1_waitrequest;
  assign rsp          = m1_readdatavalid && (inflight != '0);
  assign push         = fetching && rsp && !abort;
  assign elem_valid   = fetching && (occupancy != '0);
  assign pop          = elem_valid && elem_ready && !abort;
  assign phase_done   = pop && ((accepted + COUNT_W'(1)) == phase_count);
  assign elem_data    = fifo_mem[rd_ptr];
  assign elem_kind    = (state == S_PALETTE);
  assign elem_index   = accepted;
  assign m1_write     = (state == S_WRITE);
  assign m1_writedata = (state == S_WRITE) ? pix_data : '0;
  assign busy         = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= m1_readdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      vox_count_q   <= '0;
      pal_count_q   <= '0;
      phase_count   <= '0;
      issued        <= '0;
      accepted      <= '0;
      vox_base_q    <= '0;
      pal_base_q    <= '0;
      pix_base_q    <= '0;
      m1_address    <= '0;
      inflight      <= '0;
      occupancy     <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      pix_index     <= '0;
      clear_pixels  <= 1'b0;
      aborted       <= 1'b0;
      irq           <= 1'b0;
      abort_pending <= 1'b0;
    end else begin
      // Reads issued in the abort cycle still count, so the drain waits for their responses.
      inflight <= inflight + CNT_W'(issue) - CNT_W'(rsp);
      case (state)
        S_IDLE: begin
          if (do_render) begin
            state         <= S_CLEAR;
            vox_count_q   <= voxel_count;
            pal_count_q   <= palette_length;
            vox_base_q    <= voxel_buffer;
            pal_base_q    <= palette_buffer;
            pix_base_q    <= pixel_buffer;
            aborted       <= 1'b0;
            clear_pixels  <= 1'b1;
            pix_index     <= '0;
            abort_pending <= 1'b0;
          end
        end
        S_CLEAR: begin
          clear_pixels <= 1'b0;
          issued       <= '0;
          accepted     <= '0;
          occupancy    <= '0;
          wr_ptr       <= '0;
          rd_ptr       <= '0;
          if (abort) begin
            state <= S_ABORT_DRAIN;
          end else if (vox_count_q != '0) begin
            state       <= S_VOXELS;
            phase_count <= vox_count_q;
            m1_address  <= vox_base_q;
          end else if (pal_count_q != '0) begin
            state       <= S_PALETTE;
            phase_count <= pal_count_q;
            m1_address  <= pal_base_q;
          end else begin
            state      <= S_PIX_SETUP;
            m1_address <= pix_base_q;
          end
        end
        S_VOXELS, S_PALETTE: begin
          if (abort) begin
            state     <= S_ABORT_DRAIN;
            occupancy <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
          end else begin
            if (issue) begin
              issued     <= issued + COUNT_W'(1);
              m1_address <= m1_address + STRIDE;
            end
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop) begin
              rd_ptr   <= ptr_next(rd_ptr);
              accepted <= accepted + COUNT_W'(1);
            end
            occupancy <= occupancy + CNT_W'(push) - CNT_W'(pop);
            if (phase_done) begin
              issued   <= '0;
              accepted <= '0;
              if (state == S_VOXELS && pal_count_q != '0) begin
                state       <= S_PALETTE;
                phase_count <= pal_count_q;
                m1_address  <= pal_base_q;
              end else begin
                state      <= S_PIX_SETUP;
                m1_address <= pix_base_q;
              end
            end
          end
        end
        S_PIX_SETUP: begin
          state <= abort ? S_ABORT_DRAIN : S_WRITE;
        end
        S_WRITE: begin
          if (abort) abort_pending <= 1'b1;
          if (!m1_waitrequest) begin
            if (abort || abort_pending) begin
              state <= S_ABORT_DRAIN;
            end else if (pix_index == LAST_PIX) begin
              state <= S_INTERRUPT;
              irq   <= 1'b1;
            end else begin
              state      <= S_PIX_SETUP;
              pix_index  <= pix_index + PIX_W'(1);
              m1_address <= m1_address + STRIDE;
            end
          end
        end
        S_ABORT_DRAIN: begin
          abort_pending <= 1'b0;
          if (inflight == '0) begin
            state   <= S_IDLE;
            aborted <= 1'b1;
          end
        end
        S_INTERRUPT: begin
          if (clear_interrupt) begin
            state <= S_IDLE;
            irq   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/render_sequencer.md
# render_sequencer

Parametrised render controller for the voxel GPU. It sits between the Avalon-MM master port and the pixel-shader array. On each render it clears the shaders, then streams the voxel buffer and the palette buffer into the array through pipelined, backpressured reads. It then writes the shaded frame to the pixel buffer and raises a level interrupt. It adds multiple outstanding reads, a configurable element width, zero-length phase skipping and abort.

## Interface
- ADDR_W, 32, Avalon address width (byte addressing)
- DATA_W, 8, element and bus data width in bits; multiple of 8; address stride = DATA_W/8
- MAX_OUTSTANDING, 4, maximum reads in flight plus buffered; power of two, ≥1
- TOTAL_ROWS, 4, frame rows
- TOTAL_COLS, 4, frame columns
- COUNT_W, 24, width of voxel_count, palette_length and element indices
- PIX_W, $clog2(TOTAL_ROWS*TOTAL_COLS), pixel index width
- clock  in  1  clock
- reset  in  1  asynchronous, active-high
- do_render  in  1  start request; honoured only in IDLE
- abort  in  1  cancel the render in progress
- clear_interrupt  in  1  acknowledges irq
- voxel_buffer, palette_buffer, pixel_buffer  in  ADDR_W  base byte addresses
- voxel_count, palette_length  in  COUNT_W  element counts, sampled at start
- m1_address  out  ADDR_W  Avalon address
- m1_read, m1_write  out  1  Avalon commands
- m1_writedata  out  DATA_W  write data
- m1_waitrequest  in  1  Avalon stall
- m1_readdata  in  DATA_W  read data
- m1_readdatavalid  in  1  read response strobe
- clear_pixels  out  1  one-cycle pulse that resets the shader array
- elem_valid  out  1  element presented to the shader array
- elem_kind  out  1  0 = voxel, 1 = palette entry
- elem_index  out  COUNT_W  element ordinal within its phase
- elem_data  out  DATA_W  element value
- elem_ready  in  1  shader array accepts the element this cycle
- pix_index  out  PIX_W  pixel being read from the array
- pix_data  in  DATA_W  shaded pixel, valid one cycle after pix_index
- busy  out  1  state ≠ IDLE
- aborted  out  1  sticky: last render was aborted; cleared on the next start
- irq  out  1  render complete

## Operation
- States: IDLE, CLEAR, VOXELS, PALETTE, PIX_SETUP, WRITE, ABORT_DRAIN, INTERRUPT.
- IDLE → CLEAR on do_render. The start cycle latches the counts and bases and clears aborted.
- CLEAR lasts one cycle with clear_pixels=1. It then goes to VOXELS, or to PALETTE if voxel_count=0, or to PIX_SETUP if both counts are 0.
- Fetch phases (VOXELS, PALETTE) share one engine:
  - m1_read is asserted while issued < count and (in-flight + FIFO occupancy) < MAX_OUTSTANDING.
  - A read is issued on m1_read && !m1_waitrequest; the address then advances by DATA_W/8.
  - Responses push into a MAX_OUTSTANDING-deep FIFO. The credit rule means it never overflows.
  - The FIFO head drives elem_data, and elem_valid = !empty. elem_index is the count of elements accepted so far.
  - An element pops on elem_valid && elem_ready.
  - The phase ends once count elements have been accepted. VOXELS then goes to PALETTE (or to PIX_SETUP if palette_length=0); PALETTE goes to PIX_SETUP.
- Write phase:
  - PIX_SETUP drives pix_index and m1_address = pixel_buffer + pix_index·DATA_W/8, with the first pix_index = 0.
  - WRITE holds m1_write=1 and m1_writedata=pix_data (registered) until !m1_waitrequest.
  - The last pixel, TOTAL_ROWS·TOTAL_COLS−1, goes to INTERRUPT. Any other pixel increments pix_index and returns to PIX_SETUP.
- INTERRUPT holds irq=1 and goes to IDLE on clear_interrupt. A do_render in that same cycle is ignored.
- Abort applies in CLEAR, VOXELS, PALETTE and PIX_SETUP:
  - No new reads or elements are issued and the FIFO is flushed. The state goes to ABORT_DRAIN.
  - ABORT_DRAIN discards responses until in-flight reaches 0, then sets aborted=1 and goes to IDLE. No irq is raised.
  - Abort during WRITE completes the pending write (Avalon hold rule) and then drains.
  - Abort in IDLE or INTERRUPT is ignored.
- Arithmetic: counters are COUNT_W bits wide, and the address adder is ADDR_W bits wide and wraps modulo 2^ADDR_W.

## Timing
- Reset values: all outputs 0, state IDLE, FIFO empty, counters 0.
- With no backpressure, do_render→clear_pixels takes 1 cycle, and the first m1_read is asserted in the cycle after CLEAR.
- With zero wait states, reads issue back to back at 1 per cycle. Throughput is limited only by MAX_OUTSTANDING credit and elem_ready.
- Read data reaches elem_data no earlier than the cycle after m1_readdatavalid.
- Each pixel takes 2 cycles plus its waitstate cycles.
- A response in the same cycle as a pop is legal; occupancy is then unchanged.
- A readdatavalid that arrives while the credit is full cannot occur by construction. The bench asserts this.

## Test plan
- voxel_count=3, palette_length=2, 2×2 frame, zero waitstates, elem_ready=1:
  - elements appear in order voxel 0–2, then palette 0–1, with the correct elem_data.
  - 4 writes go to pixel_buffer+0..3, then irq.
  - clear_interrupt lowers irq and the state returns to IDLE.
- Read latency 6, MAX_OUTSTANDING=4, voxel_count=10 → never more than 4 reads outstanding, no data lost, order preserved.
- elem_ready held low for 20 cycles mid-voxel → read issue stalls once credit is exhausted; elem_data is stable while elem_valid=1.
- voxel_count=0, palette_length=0 → CLEAR is followed directly by the writes; no m1_read is ever asserted.
- Abort with 3 reads in flight → the 3 responses are discarded, aborted=1, irq stays 0, and the next do_render clears aborted and completes.
- DATA_W=32 with m1_waitrequest toggling during writes → addresses step by 4, and m1_write/m1_address are stable while stalled.
